ahb_slave_if: RTL and testbench

AHB responder-side bus interface: samples AHB address phases addressed to this slave and converts each accepted transfer into a single valid/ready request on a local backend port (register file, SRAM wrapper). It drives HREADYOUT, HRESP and HRDATA back onto the bus, and inserts wait states until the backend answers. It generates the two-cycle AHB ERROR response for illegal transfers, backend errors and backend timeouts. It sits between the AHB decoder/mux and a peripheral core, mirroring the master-side interface used by initiators.

---
 rtl/ahb_slave_if.sv | 131 +++++++++++++
 tb/tb_ahb_slave_if.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB responder: address-phase capture, backend valid/ready request, wait states and ERROR response
module ahb_slave_if #(
  parameter int AHB_ADDR_WIDTH   = 32,
  parameter int AHB_DATA_WIDTH   = 32,
  parameter int AHB_WAIT_TIMEOUT = 6
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic                      ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic [2:0]                ahb_burst_in,
  input  logic [2:0]                ahb_size_in,
  input  logic                      ahb_write_in,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
  input  logic                      ahb_ready_in,
  output logic                      ahb_readyout_out,
  output logic                      ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
  output logic                      other_valid_out,
  output logic                      other_write_out,
  output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
  output logic [2:0]                other_size_out,
  output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
  input  logic                      other_ready_in,
  input  logic                      other_error_in,
  input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in
);

  localparam int MAX_SIZE = $clog2(AHB_DATA_WIDTH / 8);
  localparam int CNT_W    = $clog2(AHB_WAIT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [AHB_ADDR_WIDTH-1:0] r_addr;
  logic                      r_write;
  logic [2:0]                r_size;
  logic [AHB_DATA_WIDTH-1:0] r_rdata;

  logic                      w_accept;
  logic                      w_legal;
  logic                      w_size_ok;
  logic                      w_aligned;
  logic                      w_timeout;
  logic [AHB_ADDR_WIDTH-1:0] w_align_mask;
  logic                      w_unused;

  assign w_unused = ^{ahb_burst_in, ahb_trans_in[0]};

  // HTRANS[1] set means NONSEQ or SEQ; IDLE/BUSY fall through as zero-wait OKAY
  always_comb begin
    w_accept = ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2)) &&
               ahb_sel_in && ahb_ready_in && ahb_trans_in[1];
    w_size_ok    = (int'(ahb_size_in) <= MAX_SIZE);
    w_align_mask = (AHB_ADDR_WIDTH'(1) << ahb_size_in) - AHB_ADDR_WIDTH'(1);
    w_aligned    = ((ahb_addr_in & w_align_mask) == '0);
    w_legal      = w_size_ok && w_aligned;
    w_timeout    = (r_cnt == CNT_W'(AHB_WAIT_TIMEOUT - 1));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (w_accept) begin
          w_next = w_legal ? S_ACCESS : S_ERR1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (other_ready_in) begin
          w_next = other_error_in ? S_ERR1 : S_DONE;
        end else if (w_timeout) begin
          w_next = S_ERR1;
        end
      end
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= ahb_addr_in;
        r_write <= ahb_write_in;
        r_size  <= ahb_size_in;
      end
      // Counter only runs while we remain in ACCESS, so every entry starts from zero
      if ((r_state == S_ACCESS) && (w_next == S_ACCESS)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if ((r_state == S_ACCESS) && other_ready_in && !other_error_in && !r_write) begin
        r_rdata <= other_rdata_in;
      end
    end
  end

  always_comb begin
    ahb_readyout_out = !((r_state == S_ACCESS) || (r_state == S_ERR1));
    ahb_resp_out     = (r_state == S_ERR1) || (r_state == S_ERR2);
    other_valid_out  = (r_state == S_ACCESS);
  end

  assign ahb_rdata_out   = r_rdata;
  assign other_write_out = r_write;
  assign other_addr_out  = r_addr;
  assign other_size_out  = r_size;
  assign other_wdata_out = ahb_wdata_in;

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - randomized transfer-level bench for ahb_slave_if
module tb_ahb_slave_if;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sel;
  logic [AW-1:0] addr;
  logic [1:0]    trans;
  logic [2:0]    burst;
  logic [2:0]    size;
  logic          wr;
  logic [DW-1:0] wdata;
  wire           ready_in;
  logic          readyout;
  logic          resp;
  logic [DW-1:0] rdata;
  logic          o_valid;
  logic          o_write;
  logic [AW-1:0] o_addr;
  logic [2:0]    o_size;
  logic [DW-1:0] o_wdata;
  logic          be_ready;
  logic          be_err;
  logic [DW-1:0] be_rdata;

  int            n_pass = 0;
  int            n_total = 0;
  int            hs_count = 0;
  int            exp_hs = 0;
  logic [DW-1:0] exp_rdata = '0;

  always #5 clk = ~clk;

  // single responder on the bus: HREADY is our own HREADYOUT
  assign ready_in = readyout;

  ahb_slave_if #(
    .AHB_ADDR_WIDTH  (AW),
    .AHB_DATA_WIDTH  (DW),
    .AHB_WAIT_TIMEOUT(T)
  ) dut (
    .ahb_clk_in      (clk),
    .ahb_rstn_in     (rstn),
    .ahb_sel_in      (sel),
    .ahb_addr_in     (addr),
    .ahb_trans_in    (trans),
    .ahb_burst_in    (burst),
    .ahb_size_in     (size),
    .ahb_write_in    (wr),
    .ahb_wdata_in    (wdata),
    .ahb_ready_in    (ready_in),
    .ahb_readyout_out(readyout),
    .ahb_resp_out    (resp),
    .ahb_rdata_out   (rdata),
    .other_valid_out (o_valid),
    .other_write_out (o_write),
    .other_addr_out  (o_addr),
    .other_size_out  (o_size),
    .other_wdata_out (o_wdata),
    .other_ready_in  (be_ready),
    .other_error_in  (be_err),
    .other_rdata_in  (be_rdata)
  );

  always @(posedge clk) begin
    if (o_valid && be_ready) hs_count <= hs_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // delay: ACCESS cycle on which the backend answers; 0 = never, T+1 = late (during ERR1)
  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [2:0] sz,
                      input logic [DW-1:0] wd, input int delay, input bit berr,
                      input logic [DW-1:0] bd);
    bit legal;
    bit answered;
    bit ok;
    int n_acc;
    legal    = ((32'd8 << sz) <= DW) && ((a & ((32'd1 << sz) - 32'd1)) == 0);
    answered = legal && (delay >= 1) && (delay <= T);
    ok       = answered && !berr;
    n_acc    = !legal ? 0 : (answered ? delay : T);
    if (answered) exp_hs++;

    sel   = 1'b1;
    trans = 2'(2 + $urandom_range(0, 1));
    addr  = a;
    size  = sz;
    wr    = w;
    burst = 3'($urandom);
    step();
    trans = 2'd0;
    sel   = 1'($urandom_range(0, 1));
    addr  = $urandom;
    size  = 3'($urandom);
    wr    = 1'($urandom);
    wdata = wd;

    for (int c = 1; c <= n_acc; c++) begin
      chk("acc_readyout", readyout, 0);
      chk("acc_resp", resp, 0);
      chk("acc_valid", o_valid, 1);
      chk("acc_addr", o_addr, a);
      chk("acc_write", o_write, w);
      chk("acc_size", o_size, sz);
      if (w) chk("acc_wdata", o_wdata, wd);
      be_ready = (c == delay);
      be_err   = (c == delay) ? berr : 1'($urandom);
      be_rdata = (c == delay) ? bd : $urandom;
      step();
    end
    be_ready = 1'b0;
    be_err   = 1'($urandom);
    be_rdata = $urandom;

    if (ok) begin
      if (!w) exp_rdata = bd;
      chk("done_readyout", readyout, 1);
      chk("done_resp", resp, 0);
      chk("done_valid", o_valid, 0);
      chk("done_rdata", rdata, exp_rdata);
    end else begin
      chk("err1_readyout", readyout, 0);
      chk("err1_resp", resp, 1);
      chk("err1_valid", o_valid, 0);
      be_ready = (delay == T + 1);
      step();
      be_ready = 1'b0;
      chk("err2_readyout", readyout, 1);
      chk("err2_resp", resp, 1);
      chk("err2_valid", o_valid, 0);
      chk("err2_rdata", rdata, exp_rdata);
    end
    chk("handshakes", hs_count, exp_hs);
  endtask

  task automatic idle_op(input bit s, input logic [1:0] t);
    sel   = s;
    trans = t;
    addr  = $urandom;
    size  = 3'($urandom);
    wr    = 1'($urandom);
    step();
    chk("idle_readyout", readyout, 1);
    chk("idle_resp", resp, 0);
    chk("idle_valid", o_valid, 0);
    sel   = 1'b0;
    trans = 2'd0;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [2:0]    rsz;
    sel = 0; addr = '0; trans = '0; burst = '0; size = '0; wr = 0; wdata = '0;
    be_ready = 0; be_err = 0; be_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_readyout", readyout, 1);
    chk("rst_resp", resp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_write", o_write, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_size", o_size, 0);
    rstn = 1'b1;

    xfer(0, 32'h100, 3'd2, '0, 2, 0, 32'hDEADBEEF);
    xfer(1, 32'h40, 3'd2, 32'h12345678, 1, 0, 32'h0BAD0BAD);
    xfer(0, 32'h44, 3'd2, '0, 1, 0, 32'hCAFEF00D);
    idle_op(0, 2'd0);
    xfer(0, 32'h102, 3'd2, '0, 1, 0, 32'h11111111);
    idle_op(0, 2'd0);
    xfer(1, 32'h0, 3'd3, 32'h55AA55AA, 1, 0, 32'h22222222);
    xfer(0, 32'h200, 3'd2, '0, 0, 0, 32'h33333333);
    xfer(0, 32'h204, 3'd2, '0, T + 1, 0, 32'h44444444);
    xfer(0, 32'h208, 3'd0, '0, 3, 1, 32'h66666666);
    xfer(0, 32'h20A, 3'd1, '0, T, 0, 32'h77777777);
    idle_op(1, 2'd1);
    idle_op(1, 2'd0);
    idle_op(0, 2'd2);

    sel = 1'b1; trans = 2'd2; addr = 32'h300; size = 3'd2; wr = 1'b0;
    step();
    sel = 1'b0; trans = 2'd0;
    chk("pre_rst_valid", o_valid, 1);
    rstn = 1'b0;
    #1;
    exp_rdata = '0;
    chk("midrst_readyout", readyout, 1);
    chk("midrst_resp", resp, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_addr", o_addr, 0);
    chk("midrst_rdata", rdata, exp_rdata);
    step();
    rstn = 1'b1;
    idle_op(1, 2'd0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: idle_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)));
        1: idle_op(1'b0, 2'($urandom_range(2, 3)));
        default: ;
      endcase
      rsz = 3'($urandom_range(0, 3));
      ra  = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rsz) - 32'd1);
      xfer(1'($urandom_range(0, 1)), ra, rsz, $urandom, $urandom_range(0, T + 1),
           ($urandom_range(0, 7) == 0), $urandom);
    end
    idle_op(0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
